// File: rtl/mure_pkg.sv
// Shared types for the MURE trace path: uop classification, lane payloads
// and the serialised beat handed to the trace encoder.
package mure_pkg;

    // Instruction class of a retired uop; STD is ordinary sequential flow.
    typedef enum logic [2:0] {
        STD  = 3'd0,
        EXC  = 3'd1,
        INT  = 3'd2,
        ERET = 3'd3,
        UJ   = 3'd4
    } itype_e;

    // One commit-port lane payload.
    typedef struct packed {
        logic [31:0] pc;
        itype_e      itype;
    } uop_entry_s;

    // Width of the retire-count field for the default MaxRun of 15.
    localparam int unsigned IretireW = 4;

    // One beat toward the encoder: the representative uop plus how many
    // uops it stands for.
    typedef struct packed {
        uop_entry_s            uop;
        logic [IretireW-1:0]   iretire;
    } ser_beat_s;

    // Ingress FSM: IDLE has an empty group buffer, DRAIN still owns lanes.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } ser_state_e;

    // Pack a uop and its retire count into a beat.
    function automatic ser_beat_s make_beat(uop_entry_s uop, logic [IretireW-1:0] cnt);
        ser_beat_s b;
        b.uop     = uop;
        b.iretire = cnt;
        return b;
    endfunction

endpackage

// File: rtl/lane_find_first.sv
// Picks the lowest valid lane at or above a start pointer, so invalid lanes
// are skipped without spending a cycle on them.
module lane_find_first #(
    parameter int unsigned NrRetiredInstr = 4,
    parameter int unsigned PtrW           = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1
) (
    input  logic [NrRetiredInstr-1:0] vld,
    input  logic [PtrW-1:0]           ptr,
    output logic                      found,
    output logic [PtrW-1:0]           idx
);

    // Scan from the top lane down so the lowest qualifying lane wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NrRetiredInstr - 1; i >= 0; i--) begin
            if (vld[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                idx   = PtrW'(i);
            end
        end
    end

endmodule

// File: rtl/ingress_serializer.sv
// Ingress stage between the commit ports and the trace encoder: buffers one
// group of retired uops, emits one beat per cycle and optionally folds runs
// of STD uops (even across groups) into a single beat with a retire count.
module ingress_serializer
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = 4,
    parameter int unsigned MaxRun         = 15
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrRetiredInstr-1:0]           ivalids_i,
    input  mure_pkg::uop_entry_s [NrRetiredInstr-1:0] uops_i,
    output logic                                ready_o,
    input  logic                                compress_en_i,
    input  logic                                flush_i,
    output logic                                valid_o,
    output mure_pkg::ser_beat_s                 beat_o,
    input  logic                                ready_i
);

    localparam int unsigned PtrW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;
    localparam int unsigned CntW = $clog2(MaxRun + 1);

    ser_state_e                       state_q, state_d;
    uop_entry_s [NrRetiredInstr-1:0]  grp_uop_q, grp_uop_d;
    logic [NrRetiredInstr-1:0]        grp_vld_q, grp_vld_d;
    logic [PtrW-1:0]                  ptr_q, ptr_d;
    uop_entry_s                       run_uop_q, run_uop_d;
    logic [CntW-1:0]                  run_cnt_q, run_cnt_d;
    logic                             out_vld_q, out_vld_d;
    ser_beat_s                        out_beat_q, out_beat_d;

    logic                             cur_found;
    logic [PtrW-1:0]                  cur_idx;
    uop_entry_s                       cur_uop;
    logic [NrRetiredInstr-1:0]        cur_onehot;
    logic                             is_last;
    logic                             slot_free;
    logic                             accept_rdy;
    logic                             advance;
    logic                             emit;
    ser_beat_s                        emit_beat;

    lane_find_first #(
        .NrRetiredInstr (NrRetiredInstr),
        .PtrW           (PtrW)
    ) u_find (
        .vld   (grp_vld_q),
        .ptr   (ptr_q),
        .found (cur_found),
        .idx   (cur_idx)
    );

    // Decode the current lane and whether it is the final one in the group.
    always_comb begin
        cur_onehot          = '0;
        cur_onehot[cur_idx] = 1'b1;
        cur_uop             = grp_uop_q[cur_idx];
        is_last             = ((grp_vld_q & ~cur_onehot) == '0);
        slot_free           = !out_vld_q || ready_i;
    end

    // Next-state, run tracking and beat generation for one lane per cycle.
    always_comb begin
        state_d    = state_q;
        grp_uop_d  = grp_uop_q;
        grp_vld_d  = grp_vld_q;
        ptr_d      = ptr_q;
        run_uop_d  = run_uop_q;
        run_cnt_d  = run_cnt_q;
        out_vld_d  = out_vld_q;
        out_beat_d = out_beat_q;
        accept_rdy = 1'b0;
        advance    = 1'b0;
        emit       = 1'b0;
        emit_beat  = '0;

        case (state_q)
            IDLE: begin
                accept_rdy = 1'b1;
                if (flush_i && (run_cnt_q != '0) && slot_free) begin
                    emit      = 1'b1;
                    emit_beat = make_beat(run_uop_q, IretireW'(run_cnt_q));
                    run_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (!cur_found) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else if (slot_free) begin
                    if ((run_cnt_q != '0) && (!compress_en_i || (cur_uop.itype != STD))) begin
                        emit      = 1'b1;
                        emit_beat = make_beat(run_uop_q, IretireW'(run_cnt_q));
                        run_cnt_d = '0;
                    end else if (compress_en_i && (cur_uop.itype == STD)) begin
                        advance   = 1'b1;
                        run_uop_d = cur_uop;
                        if (run_cnt_q == CntW'(MaxRun - 1)) begin
                            emit      = 1'b1;
                            emit_beat = make_beat(cur_uop, IretireW'(MaxRun));
                            run_cnt_d = '0;
                        end else begin
                            run_cnt_d = run_cnt_q + CntW'(1);
                        end
                    end else begin
                        advance   = 1'b1;
                        emit      = 1'b1;
                        emit_beat = make_beat(cur_uop, IretireW'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            grp_vld_d[cur_idx] = 1'b0;
            if (is_last) begin
                state_d    = IDLE;
                ptr_d      = '0;
                accept_rdy = 1'b1;
            end else begin
                ptr_d = cur_idx + PtrW'(1);
            end
        end

        if (accept_rdy && !rst_i && (|ivalids_i)) begin
            grp_uop_d = uops_i;
            grp_vld_d = ivalids_i;
            ptr_d     = '0;
            state_d   = DRAIN;
        end

        if (emit) begin
            out_vld_d  = 1'b1;
            out_beat_d = emit_beat;
        end else if (ready_i) begin
            out_vld_d = 1'b0;
        end
    end

    // State, buffer, run and output registers; reset discards everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grp_uop_q  <= '0;
            grp_vld_q  <= '0;
            ptr_q      <= '0;
            run_uop_q  <= '0;
            run_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            out_beat_q <= '0;
        end else begin
            state_q    <= state_d;
            grp_uop_q  <= grp_uop_d;
            grp_vld_q  <= grp_vld_d;
            ptr_q      <= ptr_d;
            run_uop_q  <= run_uop_d;
            run_cnt_q  <= run_cnt_d;
            out_vld_q  <= out_vld_d;
            out_beat_q <= out_beat_d;
        end
    end

    assign ready_o = accept_rdy && !rst_i;
    assign valid_o = out_vld_q;
    assign beat_o  = out_beat_q;

endmodule

// File: tb/tb_ingress_serializer.sv
// Directed bench for ingress_serializer: plain serialisation, run
// compression across groups, MaxRun saturation, flush, backpressure,
// back-to-back groups and reset mid-operation.
module tb_ingress_serializer;
    import mure_pkg::*;

    localparam int unsigned N = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N-1:0]           ivalids_i;
    uop_entry_s [N-1:0]     uops_i;
    logic                   ready_o;
    logic                   compress_en_i;
    logic                   flush_i;
    logic                   valid_o;
    ser_beat_s              beat_o;
    logic                   ready_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] pc;
        itype_e      itype;
        logic [3:0]  iretire;
        int          at;
    } rec_t;

    rec_t seen[$];

    ingress_serializer #(
        .NrRetiredInstr (N),
        .MaxRun         (15)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ivalids_i     (ivalids_i),
        .uops_i        (uops_i),
        .ready_o       (ready_o),
        .compress_en_i (compress_en_i),
        .flush_i       (flush_i),
        .valid_o       (valid_o),
        .beat_o        (beat_o),
        .ready_i       (ready_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Record every completed handshake with the cycle it happened in.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (!rst_i && valid_o && ready_i) begin
            seen.push_back('{beat_o.uop.pc, beat_o.uop.itype, beat_o.iretire, cyc});
        end
    end

    // Hard stop in case anything wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cen, input logic flush, input logic rdy);
        compress_en_i = cen;
        flush_i       = flush;
        ready_i       = rdy;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setLane(input int l, input logic [31:0] pc, input itype_e t);
        uops_i[l].pc    = pc;
        uops_i[l].itype = t;
    endtask

    // Offer a group until it is accepted; returns 1 after the accepting edge.
    task automatic sendGroup(input string tag, input logic [N-1:0] vld);
        bit ok = 1'b0;
        ivalids_i = vld;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            if (ready_o) ok = 1'b1;
            @(posedge clk_i);
            #1;
        end
        ivalids_i = '0;
        checkOutput({tag, "_accept"}, 64'(ok), 64'd1);
    endtask

    task automatic expectBeat(input string tag, input int i, input logic [31:0] pc, input itype_e t, input logic [3:0] n);
        if (i < seen.size()) begin
            checkOutput({tag, "_pc"}, 64'(seen[i].pc), 64'(pc));
            checkOutput({tag, "_itype"}, 64'(seen[i].itype), 64'(t));
            checkOutput({tag, "_iretire"}, 64'(seen[i].iretire), 64'(n));
        end else begin
            checkOutput({tag, "_present"}, 64'(seen.size()), 64'(i + 1));
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        ivalids_i = '0;
        uops_i    = '0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("rst_valid", 64'(valid_o), 64'd0);
        checkOutput("rst_beat", 64'(beat_o), 64'd0);
        checkOutput("rst_ready", 64'(ready_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Compression off, four STD lanes, one beat per cycle in lane order.
        for (int l = 0; l < 4; l++) setLane(l, 32'h100 + l, STD);
        checkOutput("t1_idle_ready", 64'(ready_o), 64'd1);
        ivalids_i = 4'b1111;
        tick();
        ivalids_i = '0;
        checkOutput("t1_no_beat_yet", 64'(valid_o), 64'd0);
        for (int l = 0; l < 4; l++) begin
            tick();
            checkOutput("t1_valid", 64'(valid_o), 64'd1);
            checkOutput("t1_pc", 64'(beat_o.uop.pc), 64'(32'h100 + l));
            checkOutput("t1_iretire", 64'(beat_o.iretire), 64'd1);
            if (l == 0) checkOutput("t1_ready_mid", 64'(ready_o), 64'd0);
            if (l == 2) checkOutput("t1_ready_last", 64'(ready_o), 64'd1);
        end
        tick();
        checkOutput("t1_valid_drop", 64'(valid_o), 64'd0);
        checkOutput("t1_count", 64'(seen.size()), 64'd4);

        // Compression on, run of 4 STD carries into the next group and is
        // closed by an EXC.
        seen.delete();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int l = 0; l < 4; l++) setLane(l, 32'h200 + l, STD);
        sendGroup("t2_g1", 4'b1111);
        setLane(0, 32'h210, STD);
        setLane(1, 32'h211, EXC);
        sendGroup("t2_g2", 4'b0011);
        repeat (8) tick();
        checkOutput("t2_count", 64'(seen.size()), 64'd2);
        expectBeat("t2_run", 0, 32'h210, STD, 4'd5);
        expectBeat("t2_exc", 1, 32'h211, EXC, 4'd1);

        // Twenty STD over five groups: saturating beat at the 15th, then
        // the tail of the run comes out on flush.
        seen.delete();
        for (int g = 0; g < 5; g++) begin
            for (int l = 0; l < 4; l++) setLane(l, 32'h300 + 4 * g + l, STD);
            sendGroup("t3_grp", 4'b1111);
        end
        repeat (6) tick();
        checkOutput("t3_count_sat", 64'(seen.size()), 64'd1);
        expectBeat("t3_sat", 0, 32'h30E, STD, 4'd15);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (3) tick();
        expectBeat("t3_flush", 1, 32'h313, STD, 4'd5);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (3) tick();
        checkOutput("t3_flush_empty", 64'(seen.size()), 64'd2);

        // Sparse valids with backpressure: lane 1 held, then lane 3.
        seen.delete();
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int l = 0; l < 4; l++) setLane(l, 32'h400 + l, STD);
        ivalids_i = 4'b1010;
        tick();
        ivalids_i = '0;
        tick();
        checkOutput("t4_first_valid", 64'(valid_o), 64'd1);
        checkOutput("t4_first_pc", 64'(beat_o.uop.pc), 64'h401);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4_hold_valid", 64'(valid_o), 64'd1);
            checkOutput("t4_hold_pc", 64'(beat_o.uop.pc), 64'h401);
        end
        ready_i = 1'b1;
        repeat (4) tick();
        checkOutput("t4_count", 64'(seen.size()), 64'd2);
        expectBeat("t4_l1", 0, 32'h401, STD, 4'd1);
        expectBeat("t4_l3", 1, 32'h403, STD, 4'd1);

        // Compression on, STD,INT then ERET back to back with no bubble.
        seen.delete();
        applyStimulus(1'b1, 1'b0, 1'b1);
        setLane(0, 32'h500, STD);
        setLane(1, 32'h501, INT);
        sendGroup("t5_a", 4'b0011);
        setLane(0, 32'h510, ERET);
        sendGroup("t5_b", 4'b0001);
        repeat (5) tick();
        checkOutput("t5_count", 64'(seen.size()), 64'd3);
        expectBeat("t5_std", 0, 32'h500, STD, 4'd1);
        expectBeat("t5_int", 1, 32'h501, INT, 4'd1);
        expectBeat("t5_eret", 2, 32'h510, ERET, 4'd1);
        if (seen.size() >= 3) begin
            checkOutput("t5_gap01", 64'(seen[1].at - seen[0].at), 64'd1);
            checkOutput("t5_gap12", 64'(seen[2].at - seen[1].at), 64'd1);
        end

        // Disabling compression flushes the open run ahead of the next lane.
        seen.delete();
        setLane(0, 32'h800, STD);
        setLane(1, 32'h801, STD);
        sendGroup("t7_a", 4'b0011);
        repeat (3) tick();
        compress_en_i = 1'b0;
        setLane(0, 32'h810, STD);
        sendGroup("t7_b", 4'b0001);
        repeat (4) tick();
        checkOutput("t7_count", 64'(seen.size()), 64'd2);
        expectBeat("t7_run", 0, 32'h801, STD, 4'd2);
        expectBeat("t7_plain", 1, 32'h810, STD, 4'd1);

        // Reset while a run beat of 3 is held under backpressure.
        seen.delete();
        applyStimulus(1'b1, 1'b0, 1'b0);
        setLane(0, 32'h600, STD);
        setLane(1, 32'h601, STD);
        setLane(2, 32'h602, STD);
        setLane(3, 32'h603, INT);
        sendGroup("t6_a", 4'b1111);
        repeat (5) tick();
        checkOutput("t6_held_valid", 64'(valid_o), 64'd1);
        checkOutput("t6_held_pc", 64'(beat_o.uop.pc), 64'h602);
        checkOutput("t6_held_iretire", 64'(beat_o.iretire), 64'd3);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput("t6_rst_valid", 64'(valid_o), 64'd0);
        checkOutput("t6_rst_beat", 64'(beat_o), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        flush_i = 1'b0;
        repeat (4) tick();
        checkOutput("t6_nothing_after_rst", 64'(seen.size()), 64'd0);

        // Reset with an open run of 3 and no beat: flush afterwards is silent.
        setLane(0, 32'h700, STD);
        setLane(1, 32'h701, STD);
        setLane(2, 32'h702, STD);
        sendGroup("t6_b", 4'b0111);
        repeat (4) tick();
        checkOutput("t6_run_open", 64'(seen.size()), 64'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (3) tick();
        checkOutput("t6_run_dropped", 64'(seen.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
